// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: BTB sizing, the 2-bit counter
// encodings, branch types and the saturating statistics increment.
package branch_predictor_pkg;

  localparam int BTB_IDX_W = 6;

  typedef enum logic [2:0] {
    NOBRANCH = 3'd0,
    BR_BEQ   = 3'd1,
    BR_BNE   = 3'd2,
    BR_BLT   = 3'd3,
    BR_BGE   = 3'd4,
    BR_BLTU  = 3'd5,
    BR_BGEU  = 3'd6
  } br_type_e;

  typedef enum logic [1:0] {
    SN = 2'b00,
    WN = 2'b01,
    WT = 2'b10,
    ST = 2'b11
  } cnt_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating up/down counter (SN..ST).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] i_cnt,
  input  logic       i_up,
  output logic [1:0] o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_up) begin
      if (i_cnt != ST) o_cnt = i_cnt + 2'b01;
    end else begin
      if (i_cnt != SN) o_cnt = i_cnt - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational IF lookup, EX-stage
// mispredict/redirect generation, table training and branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int         IDX_W    = BTB_IDX_W,
  parameter logic [1:0] CNT_INIT = WT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc_if,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_ex_br_valid,
  input  logic        i_ex_stall,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_cnt,
  output logic [31:0] o_miss_cnt
);

  localparam int N     = 2 ** IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [N-1:0]     r_valid;
  logic [TAG_W-1:0] r_tag    [N];
  logic [31:0]      r_target [N];
  logic [1:0]       r_cnt    [N];
  logic [31:0]      r_br_cnt;
  logic [31:0]      r_miss_cnt;

  logic [IDX_W-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0] w_if_tag, w_ex_tag;
  logic             w_if_hit, w_ex_hit, w_upd;
  logic [1:0]       w_cnt_next;

  assign w_if_idx = i_pc_if[IDX_W+1:2];
  assign w_if_tag = i_pc_if[31:IDX_W+2];
  assign w_ex_idx = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag = i_ex_pc[31:IDX_W+2];

  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign o_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign o_pred_target = w_if_hit ? r_target[w_if_idx] : 32'd0;

  assign w_upd    = i_ex_br_valid && !i_ex_stall;
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  // A taken branch predicted taken to the wrong target is still a mispredict.
  assign o_mispredict  = w_upd && ((i_ex_taken != i_ex_pred_taken) ||
                                   (i_ex_taken && (i_ex_pred_target != i_ex_target)));
  assign o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
  assign o_br_cnt      = r_br_cnt;
  assign o_miss_cnt    = r_miss_cnt;

  sat_counter2 u_sat_counter2 (
    .i_cnt (r_cnt[w_ex_idx]),
    .i_up  (i_ex_taken),
    .o_cnt (w_cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < N; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= SN;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_next;
        if (i_ex_taken) r_target[w_ex_idx] <= i_ex_target;
      end else if (i_ex_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= i_ex_target;
        r_cnt[w_ex_idx]    <= CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (w_upd) begin
      r_br_cnt <= sat_inc32(r_br_cnt);
      if (o_mispredict) r_miss_cnt <= sat_inc32(r_miss_cnt);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized self-checking bench for branch_predictor against a table-level
// behavioural model of the BTB, its counters and the statistics.
module tb_branch_predictor;

  localparam int IDX_W = 6;
  localparam int N     = 2 ** IDX_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_if = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_br_valid = 1'b0;
  logic        ex_stall = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] ex_pred_target = '0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b10)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pc_if          (pc_if),
    .o_pred_taken     (pred_taken),
    .o_pred_target    (pred_target),
    .i_ex_br_valid    (ex_br_valid),
    .i_ex_stall       (ex_stall),
    .i_ex_pc          (ex_pc),
    .i_ex_taken       (ex_taken),
    .i_ex_target      (ex_target),
    .i_ex_pred_taken  (ex_pred_taken),
    .i_ex_pred_target (ex_pred_target),
    .o_mispredict     (mispredict),
    .o_redirect_pc    (redirect_pc),
    .o_br_cnt         (br_cnt),
    .o_miss_cnt       (miss_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: one record per BTB slot, counter kept as an integer 0..3.
  bit          m_valid  [N];
  int unsigned m_tag    [N];
  logic [31:0] m_target [N];
  int          m_cnt    [N];
  longint      m_br;
  longint      m_miss;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % N);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_cnt[i] = 0;
    end
    m_br = 0; m_miss = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic t, output logic [31:0] tgt);
    int  i;
    bit  hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    t   = hit && (m_cnt[i] >= 2);
    tgt = hit ? m_target[i] : 32'd0;
  endtask

  task automatic step(input string name);
    logic        pt, exp_misp, upd;
    logic [31:0] ptg, exp_redir;
    int          i;
    bit          hit;
    @(negedge clk);
    model_predict(pc_if, pt, ptg);
    upd       = ex_br_valid && !ex_stall;
    exp_misp  = upd && ((ex_taken != ex_pred_taken) || (ex_taken && (ex_pred_target != ex_target)));
    exp_redir = ex_taken ? ex_target : ex_pc + 32'd4;
    check({name, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, pt});
    check({name, ".pred_target"}, pred_target, ptg);
    check({name, ".mispredict"},  {31'd0, mispredict}, {31'd0, exp_misp});
    check({name, ".redirect_pc"}, redirect_pc, exp_redir);
    check({name, ".br_cnt"},      br_cnt, 32'(m_br));
    check({name, ".miss_cnt"},    miss_cnt, 32'(m_miss));
    $display("%s pc_if=%08h pred=%0d/%08h br=%0d st=%0d ex_pc=%08h tk=%0d tgt=%08h misp=%0d redir=%08h cnt=%0d/%0d",
             name, pc_if, pred_taken, pred_target, ex_br_valid, ex_stall, ex_pc, ex_taken,
             ex_target, mispredict, redirect_pc, br_cnt, miss_cnt);
    if (upd) begin
      i   = idx_of(ex_pc);
      hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
      if (hit) begin
        m_cnt[i] = ex_taken ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3) : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
        if (ex_taken) m_target[i] = ex_target;
      end else if (ex_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_target[i] = ex_target; m_cnt[i] = 2;
      end
      if (m_br < 64'hFFFF_FFFF) m_br++;
      if (exp_misp && m_miss < 64'hFFFF_FFFF) m_miss++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] fetch_pc, input string name);
    pc_if = fetch_pc; ex_br_valid = 0; ex_stall = 0; ex_taken = 0;
    step(name);
  endtask

  // Resolve a branch whose IF prediction is what the model would have given.
  task automatic branch(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                        input logic [31:0] fetch_pc, input logic stall, input string name);
    logic        p;
    logic [31:0] ptg;
    model_predict(pc, p, ptg);
    pc_if = fetch_pc; ex_br_valid = 1; ex_stall = stall; ex_pc = pc;
    ex_taken = tk; ex_target = tgt; ex_pred_taken = p; ex_pred_target = ptg;
    step(name);
  endtask

  logic [31:0] tgt_pool [4] = '{32'h40, 32'h80, 32'hC0, 32'h400};

  function automatic logic [31:0] rand_pc();
    return (($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h2000) + (32'($urandom_range(0, 3)) << 2);
  endfunction

  initial begin
    model_clear();
    #12 rst_n = 1'b1;

    idle(32'h100, "reset");
    branch(32'h100, 1, 32'h80, 32'h100, 0, "cold_taken");
    idle(32'h100, "cold_after");
    check("cold_after.pred_taken_lit", {31'd0, pred_taken}, 32'd1);
    check("cold_after.miss_cnt_lit", miss_cnt, 32'd1);

    branch(32'h100, 0, 32'h80, 32'h100, 0, "hyst_nt1");
    idle(32'h100, "hyst_wn");
    branch(32'h100, 1, 32'h80, 32'h100, 0, "hyst_t1");
    branch(32'h100, 1, 32'h80, 32'h100, 0, "hyst_t2");
    branch(32'h100, 1, 32'h80, 32'h100, 0, "hyst_t3");
    branch(32'h100, 0, 32'h80, 32'h100, 0, "hyst_nt2");
    idle(32'h100, "hyst_wt");

    branch(32'h100, 1, 32'h80, 32'h200, 0, "alias_a");
    branch(32'h200, 1, 32'h300, 32'h100, 0, "alias_b");
    idle(32'h100, "alias_miss");
    idle(32'h200, "alias_hit");

    branch(32'h200, 1, 32'h310, 32'h200, 0, "tgt_change");
    idle(32'h200, "tgt_new");

    pc_if = 32'h200; ex_br_valid = 1; ex_stall = 1; ex_pc = 32'h200; ex_taken = 0;
    ex_target = 32'h0; ex_pred_taken = 1; ex_pred_target = 32'h310;
    step("stall");
    check("stall.mispredict_lit", {31'd0, mispredict}, 32'd0);
    idle(32'h200, "stall_after");

    for (int n = 0; n < 300; n++) begin
      logic [31:0] bpc;
      logic        p;
      logic [31:0] ptg;
      bpc = rand_pc();
      model_predict(bpc, p, ptg);
      pc_if          = rand_pc();
      ex_br_valid    = ($urandom_range(0, 9) < 7);
      ex_stall       = ($urandom_range(0, 9) < 2);
      ex_pc          = bpc;
      ex_taken       = $urandom_range(0, 1);
      ex_target      = tgt_pool[$urandom_range(0, 3)];
      ex_pred_taken  = ($urandom_range(0, 4) == 0) ? 1'($urandom_range(0, 1)) : p;
      ex_pred_target = ($urandom_range(0, 4) == 0) ? tgt_pool[$urandom_range(0, 3)] : ptg;
      step("rand");
    end

    ex_br_valid = 0; ex_stall = 0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst.br_cnt", br_cnt, 32'd0);
    check("async_rst.miss_cnt", miss_cnt, 32'd0);
    check("async_rst.mispredict", {31'd0, mispredict}, 32'd0);
    model_clear();
    #2 rst_n = 1'b1;

    for (int n = 0; n < 8; n++) idle(32'h1000 + 32'(n << 2), "post_rst");
    for (int n = 0; n < 40; n++)
      branch(rand_pc(), 1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)], rand_pc(), 0, "post_rand");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
